// File: rtl/cpu_stage_ctrl.sv
// Multi-cycle CPU stage sequencer (IF/ID/EX/MEM/WB/HALT) with strobe decode and retire counter.
// Define STAGE_SKIP_EN to let non-memory instructions bypass MEM (EX -> WB).
`timescale 1ns/1ps

module cpu_stage_ctrl #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          opcode,
    input  logic                mem_ready,
    input  logic                halt_req,
    output logic [2:0]          stage,
    output logic                mem_req,
    output logic                ir_load,
    output logic                mem_w_en,
    output logic                reg_w_en,
    output logic                pc_load,
    output logic [RETIRE_W-1:0] retired,
    output logic                halted
);

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } stage_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [RETIRE_W-1:0] RETIRE_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        logic w;
        case (op)
            OP_OP, OP_OPIMM, OP_LOAD, OP_LUI,
            OP_AUIPC, OP_JAL, OP_JALR: w = 1'b1;
            default:                   w = 1'b0;
        endcase
        return w;
    endfunction

    stage_t state;
    logic   mem_op;
    logic   store_op;
    logic   rd_op;
    logic   skip_mem;

    assign mem_op   = is_mem_op(opcode);
    assign store_op = (opcode == OP_STORE);
    assign rd_op    = writes_rd(opcode);

`ifdef STAGE_SKIP_EN
    assign skip_mem = !mem_op;
`else
    assign skip_mem = 1'b0;
`endif

    // Sequencer: reset drops any in-flight instruction without retiring it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IF;
            retired <= '0;
            halted  <= 1'b0;
        end else begin
            case (state)
                ST_IF:   if (mem_ready) state <= ST_ID;
                ST_ID:   state <= ST_EX;
                ST_EX:   state <= skip_mem ? ST_WB : ST_MEM;
                ST_MEM:  if (!mem_op || mem_ready) state <= ST_WB;
                ST_WB: begin
                    retired <= retired + RETIRE_ONE;
                    if (halt_req) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else begin
                        state  <= ST_IF;
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IF;
            endcase
        end
    end

    assign stage = state;

    // Strobes decode from the current stage so IF/MEM handshakes respond in the same cycle.
    always_comb begin
        mem_req  = 1'b0;
        ir_load  = 1'b0;
        mem_w_en = 1'b0;
        reg_w_en = 1'b0;
        pc_load  = 1'b0;
        case (state)
            ST_IF: begin
                mem_req = 1'b1;
                ir_load = mem_ready & rst;
            end
            ST_MEM: begin
                if (mem_op) begin
                    mem_req  = 1'b1;
                    mem_w_en = store_op & mem_ready;
                end
            end
            ST_WB: begin
                pc_load  = 1'b1;
                reg_w_en = rd_op;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_stage_ctrl.sv
// Directed-vector bench for cpu_stage_ctrl: sequencing, memory waits, halt, reset and counter wrap.
`timescale 1ns/1ps

module tb_cpu_stage_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        halt_req;

    logic [2:0]  stage;
    logic        mem_req, ir_load, mem_w_en, reg_w_en, pc_load, halted;
    logic [31:0] retired;

    logic [2:0]  stage4;
    logic        mem_req4, ir_load4, mem_w_en4, reg_w_en4, pc_load4, halted4;
    logic [3:0]  retired4;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

`ifdef STAGE_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam int CPI = SKIP ? 4 : 5;

    cpu_stage_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .halt_req(halt_req),
        .stage(stage), .mem_req(mem_req), .ir_load(ir_load), .mem_w_en(mem_w_en),
        .reg_w_en(reg_w_en), .pc_load(pc_load), .retired(retired), .halted(halted)
    );

    cpu_stage_ctrl #(.RETIRE_W(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .halt_req(halt_req),
        .stage(stage4), .mem_req(mem_req4), .ir_load(ir_load4), .mem_w_en(mem_w_en4),
        .reg_w_en(reg_w_en4), .pc_load(pc_load4), .retired(retired4), .halted(halted4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    function automatic int exp_stage(input int i);
        int k;
        k = i % CPI;
        if (SKIP && k == 3) return 4;
        return k;
    endfunction

    initial begin
        rst       = 1'b0;
        opcode    = OPC_OPIMM;
        mem_ready = 1'b1;
        halt_req  = 1'b0;
        #2;
        check("rst_stage",    stage,    0);
        check("rst_retired",  retired,  0);
        check("rst_halted",   halted,   0);
        check("rst_mem_req",  mem_req,  1);
        check("rst_ir_load",  ir_load,  0);
        check("rst_pc_load",  pc_load,  0);
        check("rst_reg_w_en", reg_w_en, 0);
        cyc();
        cyc();
        check("rst_hold_stage", stage, 0);

        // Back-to-back OP-IMM with zero-wait memory.
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3 * CPI; i++) begin
            check("seq_stage", stage, exp_stage(i));
            if (i == 0) check("seq_ir_load", ir_load, 1);
            if (exp_stage(i) == 3) begin
                check("seq_mem_req_nonmem",  mem_req,  0);
                check("seq_mem_w_en_nonmem", mem_w_en, 0);
            end
            if (exp_stage(i) == 4) begin
                check("seq_reg_w_en", reg_w_en, 1);
                check("seq_pc_load",  pc_load,  1);
            end
            cyc();
        end
        check("seq_retired",  retired,  3);
        check("seq_retired4", retired4, 3);
        check("seq_back_if",  stage,    0);

        // LOAD with three wait cycles in MEM.
        opcode = OPC_LOAD;
        #1;
        cyc();
        cyc();
        cyc();
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("load_wait_stage",   stage,   3);
            check("load_wait_mem_req", mem_req, 1);
            check("load_wait_reg_w",   reg_w_en, 0);
            cyc();
        end
        mem_ready = 1'b1;
        #1;
        check("load_mem4_stage", stage,    3);
        check("load_mem4_req",   mem_req,  1);
        check("load_mem4_w_en",  mem_w_en, 0);
        cyc();
        check("load_wb_stage",   stage,    4);
        check("load_wb_reg_w",   reg_w_en, 1);
        check("load_wb_retired", retired,  3);
        cyc();
        check("load_if_stage",   stage,    0);
        check("load_retired",    retired,  4);

        // STORE with zero-wait memory.
        opcode = OPC_STORE;
        #1;
        check("store_if_w_en", mem_w_en, 0);
        cyc();
        cyc();
        check("store_ex_w_en",  mem_w_en, 0);
        cyc();
        check("store_mem_stage", stage,    3);
        check("store_mem_w_en",  mem_w_en, 1);
        check("store_mem_req",   mem_req,  1);
        cyc();
        check("store_wb_stage",  stage,    4);
        check("store_wb_w_en",   mem_w_en, 0);
        check("store_wb_reg_w",  reg_w_en, 0);
        check("store_wb_pc",     pc_load,  1);
        cyc();
        check("store_retired",   retired,  5);

        // Asynchronous reset while MEM is waiting on memory.
        opcode = OPC_LOAD;
        #1;
        cyc();
        cyc();
        cyc();
        mem_ready = 1'b0;
        #1;
        cyc();
        check("midrst_wait_stage", stage, 3);
        #1;
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("midrst_stage",    stage,    0);
        check("midrst_retired",  retired,  0);
        check("midrst_retired4", retired4, 0);
        check("midrst_mem_req",  mem_req,  1);
        check("midrst_ir_load",  ir_load,  0);
        check("midrst_pc_load",  pc_load,  0);
        check("midrst_reg_w",    reg_w_en, 0);
        cyc();
        rst    = 1'b1;
        opcode = OPC_OPIMM;
        #1;
        check("midrst_rel_stage", stage,   0);
        check("midrst_rel_ir",    ir_load, 1);

        // Retire counter wrap on the 4-bit instance.
        repeat (15 * CPI) cyc();
        check("wrap15_retired4", retired4, 15);
        check("wrap15_retired",  retired,  15);
        repeat (CPI) cyc();
        check("wrap_retired4",   retired4, 0);
        check("wrap_retired",    retired,  16);
        check("wrap_stage",      stage,    0);
        check("wrap_stage4",     stage4,   0);

        // BRANCH: halt_req outside WB is ignored.
        opcode = OPC_BRANCH;
        #1;
        cyc();
        cyc();
        halt_req = 1'b1;
        #1;
        check("br_ex_stage", stage,    2);
        check("br_ex_reg_w", reg_w_en, 0);
        cyc();
        halt_req = 1'b0;
        #1;
        if (!SKIP) begin
            check("br_mem_stage", stage,    3);
            check("br_mem_req",   mem_req,  0);
            check("br_mem_w_en",  mem_w_en, 0);
            cyc();
        end
        check("br_wb_stage",  stage,    4);
        check("br_wb_reg_w",  reg_w_en, 0);
        check("br_wb_w_en",   mem_w_en, 0);
        check("br_wb_pc",     pc_load,  1);
        cyc();
        check("br_ignored_stage",  stage,   0);
        check("br_ignored_halted", halted,  0);
        check("br_retired",        retired, 17);

        // BRANCH with halt_req held through WB.
        halt_req = 1'b1;
        #1;
        repeat (CPI - 1) cyc();
        check("halt_wb_stage", stage, 4);
        cyc();
        check("halt_stage",   stage,   5);
        check("halt_halted",  halted,  1);
        check("halt_retired", retired, 18);
        check("halt_mem_req", mem_req, 0);
        check("halt_pc_load", pc_load, 0);
        halt_req = 1'b0;
        #1;
        repeat (3) cyc();
        check("halt_sticky_stage",   stage,   5);
        check("halt_sticky_halted",  halted,  1);
        check("halt_sticky_retired", retired, 18);
        check("halt_sticky_ir",      ir_load, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_stage_ctrl.md
CPU_STAGE_CTRL -- requirements
Module: cpu_stage_ctrl

Interface
REQ-001 SHALL have parameter RETIRE_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low (0 = in reset).
REQ-004 SHALL have port opcode  input  7  IR opcode field, valid from ID through WB.
REQ-005 SHALL have port mem_ready  input  1  memory completes the current access this cycle.
REQ-006 SHALL have port halt_req  input  1  request to stop after the current instruction.
REQ-007 SHALL have port stage  output  3  current stage: 0 IF, 1 ID, 2 EX, 3 MEM, 4 WB, 5 HALT.
REQ-008 SHALL have port mem_req  output  1  memory access request.
REQ-009 SHALL have port ir_load  output  1  load IR from memory data.
REQ-010 SHALL have port mem_w_en  output  1  data-memory write strobe.
REQ-011 SHALL have port reg_w_en  output  1  register-file write strobe.
REQ-012 SHALL have port pc_load  output  1  load PC from next_pc.
REQ-013 SHALL have port retired  output  RETIRE_W  count of completed instructions.
REQ-014 SHALL have port halted  output  1  high while stage = HALT.

Function
REQ-015 SHALL classify opcode: LOAD 0000011, STORE 0100011 are memory ops; OP 0110011, OP-IMM 0010011, LOAD, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111 write rd; all others (incl. BRANCH, unknown) write nothing.
REQ-016 IF SHALL assert mem_req; on the cycle mem_ready=1 it SHALL assert ir_load (same cycle, combinational) and go to ID; otherwise remain in IF.
REQ-017 ID SHALL last exactly 1 cycle, then EX; EX SHALL last exactly 1 cycle, then MEM.
REQ-018 MEM for a memory op SHALL assert mem_req and wait for mem_ready; for STORE, mem_w_en SHALL equal mem_ready; on mem_ready go to WB.
REQ-019 MEM for a non-memory op SHALL last 1 cycle with mem_req=0, mem_w_en=0 (see REQ-027 for skip).
REQ-020 WB SHALL last exactly 1 cycle: pc_load=1, reg_w_en=1 iff opcode writes rd, retired increments by 1 at the cycle end.
REQ-021 From WB SHALL go to HALT if halt_req=1 in the WB cycle, else to IF; halt_req in any other stage SHALL be ignored.
REQ-022 HALT SHALL be sticky until reset; all strobes 0, halted=1, retired frozen.
REQ-023 retired SHALL wrap from 2^RETIRE_W-1 to 0 without side effects.
REQ-024 Strobes SHALL be 0 in every stage not named above for them; mem_ready outside IF/memory-MEM SHALL be ignored.

Reset
REQ-025 While rst=0, SHALL force stage=IF(0), retired=0, halted=0, and all strobes except mem_req to 0 asynchronously; mem_req=1 (IF decode), but ir_load SHALL be held 0 during reset.
REQ-026 Reset mid-instruction (any stage, incl. MEM waiting on mem_ready) SHALL abandon the instruction with no pc_load, reg_w_en or retire; first post-reset edge evaluates IF.

Configuration
REQ-027 With STAGE_SKIP_EN defined, non-memory ops SHALL go EX -> WB directly (4 cycles with zero-wait fetch); without it, every instruction SHALL pass through MEM (5 cycles minimum).

Verification
REQ-028 Reset release, mem_ready=1 always, opcode=0010011 repeated -> stage sequence 0,1,2,3,4,0; reg_w_en=1 in each WB; retired=3 after 15 cycles (12 cycles with STAGE_SKIP_EN).
REQ-029 Opcode 0000011, mem_ready low 3 cycles in MEM -> stage holds 3 for 4 cycles, mem_req=1 throughout, then WB with reg_w_en=1, retired+1.
REQ-030 Opcode 0100011, mem_ready=1 -> mem_w_en=1 exactly one cycle in MEM, reg_w_en=0 in WB, pc_load=1.
REQ-031 Opcode 1100011 -> no reg_w_en, no mem_w_en; halt_req pulsed in EX -> ignored; held through WB -> stage=5, halted=1, retired stops.
REQ-032 rst=0 asserted while stage=3 waiting -> stage=0, retired=0 immediately (before next edge); RETIRE_W=4 and 16 instructions -> retired wraps to 0.
